spi_target: RTL
===============

SPI_TARGET -- requirements
Module: spi_target

Interface
REQ-001 Parameter WIDTH, default 8, frame length in bits (≥2).
REQ-002 Parameter SYNC_STAGES, default 2, synchronizer depth for sclk/cs_n/mosi (≥2).
REQ-003 clk  input  1  system clock; all logic on posedge clk.
REQ-004 rstn  input  1  asynchronous active-low reset.
REQ-005 sclk  input  1  SPI serial clock from initiator, asynchronous to clk.
REQ-006 cs_n  input  1  SPI chip select, active-low, asynchronous.
REQ-007 mosi  input  1  serial data from initiator.
REQ-008 miso  output  1  serial data to initiator, registered.
REQ-009 tx_data  input  WIDTH  word to transmit in a following frame.
REQ-010 tx_valid  input  1  tx_data valid.
REQ-011 tx_ready  output  1  holding register empty, word accepted on tx_valid&&tx_ready.
REQ-012 rx_data  output  WIDTH  last completely received word.
REQ-013 rx_valid  output  1  one-cycle pulse, rx_data updated.
REQ-014 busy  output  1  high in state SHIFT.
REQ-015 underrun  output  1  sticky tx-underrun flag (see Configuration).
REQ-016 underrun_clr  input  1  clears underrun.

Function
REQ-017 sclk, cs_n, mosi SHALL each pass a SYNC_STAGES flip-flop synchronizer; sclk edges are detected from the last two synchronized samples.
REQ-018 Supported: SPI mode 0 only (sample mosi on sclk rise, update miso on sclk fall), MSB first; sclk frequency ≤ clk/8.
REQ-019 States: IDLE (synced cs_n high) and SHIFT (synced cs_n low).
REQ-020 IDLE->SHIFT on synced cs_n falling: tx shift register loads holding register (or all zeros if empty), holding marked empty, bit counter cleared, miso driven with loaded MSB on the next clk.
REQ-021 In SHIFT, each synced sclk rise SHALL shift mosi into the rx shift register LSB and increment the bit counter.
REQ-022 In SHIFT, each synced sclk fall SHALL shift the tx register left one bit and drive the new MSB on miso.
REQ-023 When the counter reaches WIDTH: rx_data takes the assembled word, rx_valid pulses one cycle, counter clears, tx register reloads per REQ-020 (back-to-back frames without cs_n deassertion).
REQ-024 rx_valid SHALL rise exactly SYNC_STAGES+2 clk cycles after the raw sclk rising edge of the last bit.
REQ-025 tx_ready = holding empty; on accept, holding captures tx_data next cycle.
REQ-026 Simultaneous accept and frame load: the load uses the holding value before the accept (zeros if it was empty); the accepted word remains held for the next frame.
REQ-027 SHIFT->IDLE on synced cs_n rising at any bit count: partial rx word discarded, no rx_valid, rx_data unchanged, counter cleared, in-flight tx word dropped, holding register unaffected.
REQ-028 miso SHALL be 0 in IDLE (no tristate).
REQ-029 rx_data holds its value until the next completed frame; no receive back-pressure.

Reset
REQ-030 On rstn low: state IDLE, miso 0, rx_data 0, rx_valid 0, busy 0, tx_ready 1, underrun 0, counter 0, shift registers 0, synchronizers set to idle levels (sclk 0, cs_n 1, mosi 0).
REQ-031 Reset mid-frame SHALL abort the frame without rx_valid; after release the block waits for a fresh synced cs_n falling edge.

Configuration
REQ-032 Macro SPI_TARGET_UNDERRUN_EN: when defined, underrun SHALL set on any frame load with empty holding register and clear on underrun_clr (set wins on the same cycle).
REQ-033 Without SPI_TARGET_UNDERRUN_EN: underrun tied 0, underrun_clr ignored, no flag logic.

Structure
REQ-034 Shared package spi_pkg: state enumeration (IDLE, SHIFT), SPI mode constant, default WIDTH and SYNC_STAGES.
REQ-035 One sub-module spi_sync: SYNC_STAGES-deep synchronizer with parameterized reset value, instantiated three times.

Verification
REQ-036 Reset, then cs_n low, 8 sclk with mosi=0xA5, tx holding 0x3C -> rx_data=0xA5, one rx_valid pulse, miso sampled by bench=0x3C.
REQ-037 Two back-to-back frames, cs_n held low, mosi 0x01 then 0xFF, holding refilled between -> two rx_valid pulses, rx_data 0x01 then 0xFF.
REQ-038 cs_n rises after 5 bits -> no rx_valid, rx_data unchanged, busy 0 within SYNC_STAGES+1 cycles.
REQ-039 Frame with empty holding -> miso=0x00 every bit; with SPI_TARGET_UNDERRUN_EN underrun=1 until underrun_clr, without it underrun stays 0.
REQ-040 tx_valid asserted in the same cycle as the frame load -> current frame sends prior holding word, next frame sends new word, tx_ready low in between.
REQ-041 rstn asserted after 3 bits -> all outputs at reset values; next full frame 0x5A received correctly.

Source files
------------

// File: rtl/spi_pkg.sv
// Shared definitions for the SPI target: FSM states, supported mode and default sizing.
package spi_pkg;

    typedef enum logic {StIdle, StShift} spi_state_e;

    localparam int unsigned SpiMode           = 0;
    localparam int unsigned DefaultWidth      = 8;
    localparam int unsigned DefaultSyncStages = 2;

endpackage

// File: rtl/spi_sync.sv
// Multi-stage flip-flop synchronizer for one asynchronous input, with configurable reset level.
module spi_sync #(
    parameter int unsigned STAGES    = 2,
    parameter logic        RESET_VAL = 1'b0
) (
    input  logic clk,
    input  logic rstn,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] sync_q;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            sync_q <= {STAGES{RESET_VAL}};
        end else begin
            sync_q <= {sync_q[STAGES-2:0], d};
        end
    end

    assign q = sync_q[STAGES-1];

endmodule

// File: rtl/spi_target.sv
// SPI mode-0 target (MSB first) with a one-word tx holding register.
// Optional sticky tx-underrun flag enabled by defining SPI_TARGET_UNDERRUN_EN.
module spi_target
    import spi_pkg::*;
#(
    parameter int unsigned WIDTH       = DefaultWidth,
    parameter int unsigned SYNC_STAGES = DefaultSyncStages
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             sclk,
    input  logic             cs_n,
    input  logic             mosi,
    output logic             miso,
    input  logic [WIDTH-1:0] tx_data,
    input  logic             tx_valid,
    output logic             tx_ready,
    output logic [WIDTH-1:0] rx_data,
    output logic             rx_valid,
    output logic             busy,
    output logic             underrun,
    input  logic             underrun_clr
);

    localparam int unsigned CntW = $clog2(WIDTH + 1);
    localparam logic [CntW-1:0] CntFull = CntW'(WIDTH);

    logic sclk_s, cs_n_s, mosi_s;
    logic sclk_prev_q;
    logic sclk_rise, sclk_fall;

    spi_sync #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_sclk (
        .clk  (clk),
        .rstn (rstn),
        .d    (sclk),
        .q    (sclk_s)
    );

    spi_sync #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_sync_cs_n (
        .clk  (clk),
        .rstn (rstn),
        .d    (cs_n),
        .q    (cs_n_s)
    );

    spi_sync #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_mosi (
        .clk  (clk),
        .rstn (rstn),
        .d    (mosi),
        .q    (mosi_s)
    );

    assign sclk_rise = sclk_s & ~sclk_prev_q;
    assign sclk_fall = ~sclk_s & sclk_prev_q;

    spi_state_e       state_q, state_d;
    logic [CntW-1:0]  cnt_q, cnt_d;
    logic [WIDTH-1:0] rx_sr_q, rx_sr_d;
    logic [WIDTH-1:0] tx_sr_q, tx_sr_d;
    logic [WIDTH-1:0] rx_data_q, rx_data_d;
    logic [WIDTH-1:0] hold_q, hold_d;
    logic [WIDTH-1:0] load_word;
    logic             hold_full_q, hold_full_d;
    logic             miso_q, miso_d;
    logic             rx_valid_q, rx_valid_d;
    logic             load, accept;

    assign accept    = tx_valid & ~hold_full_q;
    // A load always sees the pre-accept holding state, so a same-cycle accept survives.
    assign load_word = hold_full_q ? hold_q : '0;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        rx_sr_d    = rx_sr_q;
        tx_sr_d    = tx_sr_q;
        miso_d     = miso_q;
        rx_data_d  = rx_data_q;
        rx_valid_d = 1'b0;
        load       = 1'b0;

        unique case (state_q)
            StIdle: begin
                miso_d = 1'b0;
                if (!cs_n_s) begin
                    state_d = StShift;
                    cnt_d   = '0;
                    rx_sr_d = '0;
                    load    = 1'b1;
                end
            end
            StShift: begin
                if (cs_n_s) begin
                    state_d = StIdle;
                    cnt_d   = '0;
                    rx_sr_d = '0;
                    tx_sr_d = '0;
                    miso_d  = 1'b0;
                end else if (cnt_q == CntFull) begin
                    rx_data_d  = rx_sr_q;
                    rx_valid_d = 1'b1;
                    cnt_d      = '0;
                    load       = 1'b1;
                end else if (sclk_rise) begin
                    rx_sr_d = {rx_sr_q[WIDTH-2:0], mosi_s};
                    cnt_d   = cnt_q + 1'b1;
                end else if (sclk_fall && cnt_q != '0) begin
                    // Count of zero means the trailing fall of the previous frame: keep the new MSB.
                    tx_sr_d = {tx_sr_q[WIDTH-2:0], 1'b0};
                    miso_d  = tx_sr_q[WIDTH-2];
                end
            end
            default: state_d = StIdle;
        endcase

        if (load) begin
            tx_sr_d = load_word;
            miso_d  = load_word[WIDTH-1];
        end
    end

    always_comb begin
        hold_d      = hold_q;
        hold_full_d = hold_full_q;
        if (accept) begin
            hold_d      = tx_data;
            hold_full_d = 1'b1;
        end else if (load) begin
            hold_full_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q     <= StIdle;
            cnt_q       <= '0;
            rx_sr_q     <= '0;
            tx_sr_q     <= '0;
            miso_q      <= 1'b0;
            rx_data_q   <= '0;
            rx_valid_q  <= 1'b0;
            hold_q      <= '0;
            hold_full_q <= 1'b0;
            sclk_prev_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            rx_sr_q     <= rx_sr_d;
            tx_sr_q     <= tx_sr_d;
            miso_q      <= miso_d;
            rx_data_q   <= rx_data_d;
            rx_valid_q  <= rx_valid_d;
            hold_q      <= hold_d;
            hold_full_q <= hold_full_d;
            sclk_prev_q <= sclk_s;
        end
    end

`ifdef SPI_TARGET_UNDERRUN_EN
    logic underrun_q;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            underrun_q <= 1'b0;
        end else if (load && !hold_full_q) begin
            underrun_q <= 1'b1;
        end else if (underrun_clr) begin
            underrun_q <= 1'b0;
        end
    end

    assign underrun = underrun_q;
`else
    logic unused_underrun_clr;
    assign unused_underrun_clr = underrun_clr;
    assign underrun            = 1'b0;
`endif

    assign miso     = miso_q;
    assign rx_data  = rx_data_q;
    assign rx_valid = rx_valid_q;
    assign busy     = (state_q == StShift);
    assign tx_ready = ~hold_full_q;

endmodule
